// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM model with fixed BUSY latency and one-cycle ACCESS pulse
// Optional statistics counters are enabled by defining RAM_STATS_EN.
module ram_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
`ifdef RAM_STATS_EN
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [15:0] err_count,
`endif
    output logic [1:0]  ramstate
);
    localparam int AW = $clog2(DEPTH);

    generate
        if (LAT < 1 || LAT > 15) begin : g_bad_lat
            $error("ram_responder: LAT must be 1..15");
        end
        if ((1 << AW) != DEPTH) begin : g_bad_depth
            $error("ram_responder: DEPTH must be a power of two");
        end
    endgenerate

    // Encoding matches ramstate: FREE, BUSY, ACCESS, ERROR
    typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ren_q, wen_q;
    logic [31:0] addr_q, store_q, load_q;
    logic [31:0] mem [DEPTH];

    logic req, bad, ok, changed, lat, fire;
    logic [AW-1:0] idx;

    assign req     = ramREN | ramWEN;
    assign bad     = (ramREN & ramWEN) | (|ramaddr[1:0]) | (ramaddr >= 32'(DEPTH * 4));
    assign ok      = req & ~bad;
    assign changed = {ramREN, ramWEN, ramaddr, ramstore} != {ren_q, wen_q, addr_q, store_q};
    // A new request is captured from every state except an unchanged WAIT
    assign lat     = ok & ((state_q != WAIT) | changed);
    // Only reachable with live inputs equal to the latch, so the latched request is legal
    assign fire    = (state_q == WAIT) & ok & ~changed & (cnt_q == 4'd0);
    assign idx     = addr_q[AW+1:2];
    assign ramstate = state_q;
    assign ramload  = load_q;

    // Next state and latency counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!req) state_d = IDLE;
        else if (bad) state_d = ERR;
        else if (lat) begin
            state_d = WAIT;
            cnt_d   = 4'(LAT - 1);
        end
        else if (fire) state_d = ACC;
        else cnt_d = cnt_q - 4'd1;
    end

    // State, request latch and read data registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (lat) begin
                ren_q   <= ramREN;
                wen_q   <= ramWEN;
                addr_q  <= ramaddr;
                store_q <= ramstore;
            end
            if (fire & ren_q) load_q <= mem[idx];
        end
    end

    // Memory array is never cleared; writes commit only on the WAIT->ACC edge
    always_ff @(posedge CLK) begin
        if (fire & wen_q) mem[idx] <= store_q;
    end

`ifdef RAM_STATS_EN
    logic [31:0] rd_q, wr_q;
    logic [15:0] err_q;

    assign rd_count  = rd_q;
    assign wr_count  = wr_q;
    assign err_count = err_q;

    // Completed access counters and saturating error-entry counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_q  <= '0;
            wr_q  <= '0;
            err_q <= '0;
        end else begin
            if (fire & ren_q) rd_q <= rd_q + 32'd1;
            if (fire & wen_q) wr_q <= wr_q + 32'd1;
            if (state_d == ERR && state_q != ERR && err_q != '1) err_q <= err_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed self-checking bench for ram_responder (DEPTH=1024, LAT=2)
module tb_ram_responder;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
`ifdef RAM_STATS_EN
    logic [31:0] rd_count, wr_count;
    logic [15:0] err_count;
`endif
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] d;
    int c;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    ram_responder #(.DEPTH(1024), .LAT(2)) dut (
        .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
`ifdef RAM_STATS_EN
        .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count),
`endif
        .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s);
        ramREN = r;
        ramWEN = w;
        ramaddr = a;
        ramstore = s;
    endtask

    task automatic do_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s,
                         output logic [31:0] data, output int cyc);
        drive(r, w, a, s);
        cyc = 0;
        while (ramstate != ACCESS && cyc < 20) begin
            step();
            cyc++;
        end
        if (cyc >= 20) check("op_timeout", 32'(ramstate), 32'(ACCESS));
        data = ramload;
        drive(0, 0, 0, 0);
        step();
    endtask

    initial begin
        nRST = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        check("rst_state", 32'(ramstate), 32'(FREE));
        check("rst_load", ramload, 32'h0);
`ifdef RAM_STATS_EN
        check("rst_rd", rd_count, 0);
        check("rst_err", 32'(err_count), 0);
`endif
        @(negedge CLK);
        nRST = 1'b1;
        step();

        drive(0, 1, 32'h40, 32'hDEADBEEF);
        check("t1_c0", 32'(ramstate), 32'(FREE));
        step(); check("t1_c1", 32'(ramstate), 32'(BUSY));
        step(); check("t1_c2", 32'(ramstate), 32'(BUSY));
        step(); check("t1_c3", 32'(ramstate), 32'(ACCESS));
        check("t1_wr_load", ramload, 32'h0);
        drive(0, 0, 0, 0);
        step(); check("t1_free", 32'(ramstate), 32'(FREE));
        do_op(1, 0, 32'h40, 0, d, c);
        check("t1_rd", d, 32'hDEADBEEF);
        check("t1_lat", c, 3);

        do_op(0, 1, 32'h44, 32'h44444444, d, c);
        do_op(0, 1, 32'h10, 32'h10101010, d, c);
        do_op(0, 1, 32'h0, 32'hC0DE0000, d, c);
        do_op(0, 1, 32'h80, 32'h00000F0F, d, c);
        do_op(0, 1, 32'h100, 32'h00005555, d, c);
        check("wr_nochg_load", d, 32'hDEADBEEF);

        drive(1, 0, 32'h40, 0);
        step(); step(); step();
        check("t2_acc0", 32'(ramstate), 32'(ACCESS));
        step(); check("t2_b1", 32'(ramstate), 32'(BUSY));
        step(); check("t2_b2", 32'(ramstate), 32'(BUSY));
        step(); check("t2_acc1", 32'(ramstate), 32'(ACCESS));
        check("t2_load1", ramload, 32'hDEADBEEF);
        step(); check("t2_b3", 32'(ramstate), 32'(BUSY));
        drive(1, 0, 32'h44, 0);
        step(); check("t2_rs1", 32'(ramstate), 32'(BUSY));
        step(); check("t2_rs2", 32'(ramstate), 32'(BUSY));
        step(); check("t2_acc2", 32'(ramstate), 32'(ACCESS));
        check("t2_load2", ramload, 32'h44444444);
        drive(0, 0, 0, 0);
        step(); check("t2_free", 32'(ramstate), 32'(FREE));

        drive(1, 1, 32'h10, 32'hBAD0BAD0);
        check("t3_c0", 32'(ramstate), 32'(FREE));
        step(); check("t3_err1", 32'(ramstate), 32'(ERROR));
        step(); check("t3_err2", 32'(ramstate), 32'(ERROR));
        drive(0, 0, 0, 0);
        step(); check("t3_free", 32'(ramstate), 32'(FREE));
        do_op(1, 0, 32'h10, 0, d, c);
        check("t3_mem", d, 32'h10101010);

        drive(0, 1, 32'h42, 32'h1234);
        step(); check("t4_mis1", 32'(ramstate), 32'(ERROR));
        step(); check("t4_mis2", 32'(ramstate), 32'(ERROR));
        drive(0, 1, 32'h40, 32'h1234);
        step(); check("t4_fix_b1", 32'(ramstate), 32'(BUSY));
        step(); check("t4_fix_b2", 32'(ramstate), 32'(BUSY));
        step(); check("t4_fix_acc", 32'(ramstate), 32'(ACCESS));
        drive(0, 0, 0, 0);
        step();
        do_op(1, 0, 32'h40, 0, d, c);
        check("t4_fix_mem", d, 32'h1234);
        drive(0, 1, 32'h1000, 32'hBAD1BAD1);
        step(); check("t4_range", 32'(ramstate), 32'(ERROR));
        drive(0, 0, 0, 0);
        step(); check("t4_range_free", 32'(ramstate), 32'(FREE));
        do_op(1, 0, 32'h0, 0, d, c);
        check("t4_range_mem", d, 32'hC0DE0000);
`ifdef RAM_STATS_EN
        check("st_err", 32'(err_count), 3);
`endif

        drive(0, 1, 32'h80, 32'h1111);
        step(); check("t5_ab_busy", 32'(ramstate), 32'(BUSY));
        drive(0, 0, 0, 0);
        step(); check("t5_ab_free", 32'(ramstate), 32'(FREE));
        do_op(1, 0, 32'h80, 0, d, c);
        check("t5_ab_mem", d, 32'h00000F0F);
        drive(0, 1, 32'h80, 32'h1111);
        step();
        drive(0, 1, 32'h80, 32'h2222);
        step(); check("t5_rs_b2", 32'(ramstate), 32'(BUSY));
        step(); check("t5_rs_b3", 32'(ramstate), 32'(BUSY));
        step(); check("t5_rs_acc", 32'(ramstate), 32'(ACCESS));
        drive(0, 0, 0, 0);
        step();
        do_op(1, 0, 32'h80, 0, d, c);
        check("t5_rs_mem", d, 32'h2222);

        drive(0, 1, 32'h100, 32'hAAAA);
        step(); check("t6_busy", 32'(ramstate), 32'(BUSY));
        #2 nRST = 1'b0;
        #1;
        check("t6_state", 32'(ramstate), 32'(FREE));
        check("t6_load", ramload, 32'h0);
`ifdef RAM_STATS_EN
        check("t6_rd", rd_count, 0);
        check("t6_wr", wr_count, 0);
        check("t6_err", 32'(err_count), 0);
`endif
        drive(0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        check("t6_free", 32'(ramstate), 32'(FREE));
        do_op(1, 0, 32'h100, 0, d, c);
        check("t6_mem", d, 32'h5555);
        check("t6_lat", c, 3);
`ifdef RAM_STATS_EN
        check("t6_rd1", rd_count, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
